// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_arbiter
// Purpose  : Round-robin arbiter that lets two requesters share one external
//            combinational ALU. The winning command is registered onto the
//            ALU drive lines, and the result is captured into a single
//            response channel that is tagged with the requester ID.
// Revision : 1.0 - initial release
// ============================================================================
module alu_req_arbiter #(
   parameter int BUS   = 8,
   parameter int ERR_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   // requester 0
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic [3:0]       r0_op,
   input  logic [BUS-1:0]   r0_a,
   input  logic [BUS-1:0]   r0_b,
   input  logic             r0_cin,
   // requester 1
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic [3:0]       r1_op,
   input  logic [BUS-1:0]   r1_a,
   input  logic [BUS-1:0]   r1_b,
   input  logic             r1_cin,
   // ALU side
   output logic [3:0]       alu_op,
   output logic [BUS-1:0]   alu_a,
   output logic [BUS-1:0]   alu_b,
   output logic             alu_cin,
   input  logic [BUS-1:0]   alu_y,
   input  logic [4:0]       alu_flags,
   // response channel
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [BUS-1:0]   rsp_y,
   output logic [4:0]       rsp_flags,
   output logic             busy,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_rr_ptr;
   logic             w_grant;
   logic             w_any_valid;
   logic             w_r0_ready;
   logic             w_r1_ready;
   logic             w_hs;
   logic [3:0]       w_sel_op;
   logic [BUS-1:0]   w_sel_a;
   logic [BUS-1:0]   w_sel_b;
   logic             w_sel_cin;

   logic [3:0]       r_alu_op;
   logic [BUS-1:0]   r_alu_a;
   logic [BUS-1:0]   r_alu_b;
   logic             r_alu_cin;
   logic             r_rsp_valid;
   logic             r_rsp_id;
   logic [BUS-1:0]   r_rsp_y;
   logic [4:0]       r_rsp_flags;
   logic [ERR_W-1:0] r_err_cnt;

   // Winner: a lone valid requester wins outright; a tie is broken by rr_ptr.
   assign w_any_valid = r0_valid | r1_valid;
   assign w_grant     = (r0_valid & r1_valid) ? r_rr_ptr : r1_valid;
   assign w_hs        = w_r0_ready | w_r1_ready;

   assign w_sel_op    = w_grant ? r1_op  : r0_op;
   assign w_sel_a     = w_grant ? r1_a   : r0_a;
   assign w_sel_b     = w_grant ? r1_b   : r0_b;
   assign w_sel_cin   = w_grant ? r1_cin : r0_cin;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and ready generation; ready is forced low while reset is held.
   always_comb begin
      w_state_nxt = r_state;
      w_r0_ready  = 1'b0;
      w_r1_ready  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_valid && rst_n) begin
               w_r0_ready  = ~w_grant & r0_valid;
               w_r1_ready  =  w_grant & r1_valid;
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC:  w_state_nxt = S_RESP;
         S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Command latch, round-robin pointer, result capture and error counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr    <= 1'b0;
         r_alu_op    <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_cin   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_y     <= '0;
         r_rsp_flags <= '0;
         r_err_cnt   <= '0;
      end else begin
         if (w_hs) begin
            r_alu_op  <= w_sel_op;
            r_alu_a   <= w_sel_a;
            r_alu_b   <= w_sel_b;
            r_alu_cin <= w_sel_cin;
            r_rsp_id  <= w_grant;
            r_rr_ptr  <= ~w_grant;
         end
         if (r_state == S_EXEC) begin
            r_rsp_y     <= alu_y;
            r_rsp_flags <= alu_flags;
            r_rsp_valid <= 1'b1;
            if (alu_flags[4] && (r_err_cnt != {ERR_W{1'b1}}))
               r_err_cnt <= r_err_cnt + 1'b1;
         end
         if ((r_state == S_RESP) && r_rsp_valid && rsp_ready)
            r_rsp_valid <= 1'b0;
      end
   end

   assign r0_ready  = w_r0_ready;
   assign r1_ready  = w_r1_ready;
   assign alu_op    = r_alu_op;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_cin   = r_alu_cin;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_y     = r_rsp_y;
   assign rsp_flags = r_rsp_flags;
   assign err_cnt   = r_err_cnt;
   assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_req_arbiter
// Purpose  : Directed self-checking bench for alu_req_arbiter, with a small
//            behavioural model of the external ALU wired beside the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_req_arbiter;

   localparam int BUS   = 8;
   localparam int ERR_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             r0_valid = 1'b0, r1_valid = 1'b0;
   logic             r0_ready, r1_ready;
   logic [3:0]       r0_op = '0, r1_op = '0;
   logic [BUS-1:0]   r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
   logic             r0_cin = 1'b0, r1_cin = 1'b0;
   logic [3:0]       alu_op;
   logic [BUS-1:0]   alu_a, alu_b, alu_y;
   logic             alu_cin;
   logic [4:0]       alu_flags;
   logic             rsp_valid, rsp_id, busy;
   logic             rsp_ready = 1'b0;
   logic [BUS-1:0]   rsp_y;
   logic [4:0]       rsp_flags;
   logic [ERR_W-1:0] err_cnt;

   int checks = 0;
   int errors = 0;

   alu_req_arbiter #(.BUS(BUS), .ERR_W(ERR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op),
      .r0_a(r0_a), .r0_b(r0_b), .r0_cin(r0_cin),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op),
      .r1_a(r1_a), .r1_b(r1_b), .r1_cin(r1_cin),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
      .alu_y(alu_y), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_y(rsp_y), .rsp_flags(rsp_flags), .busy(busy), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // External ALU model: flags = {invalid_op, parity, zero, borrow, carry_out}.
   always_comb begin
      logic [8:0] t;
      logic       inv, co, bo;
      t   = '0;
      inv = 1'b0;
      co  = 1'b0;
      bo  = 1'b0;
      case (alu_op)
         4'd1: begin t = {1'b0, alu_a} + {1'b0, alu_b};                co = t[8]; end
         4'd2: begin t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin}; co = t[8]; end
         4'd3: begin t = {1'b0, alu_a} - {1'b0, alu_b};                bo = t[8]; end
         4'd4: begin t = {1'b0, alu_a} + 9'd1;                         co = t[8]; end
         4'd5: begin t = {1'b0, alu_a} - 9'd1;                         bo = t[8]; end
         4'd6: t = {1'b0, alu_a & alu_b};
         4'd7: t = {1'b0, ~alu_a};
         4'd8: begin t = {1'b0, alu_a[6:0], alu_a[7]};                 co = alu_a[7]; end
         4'd9: begin t = {1'b0, alu_a[0], alu_a[7:1]};                 co = alu_a[0]; end
         default: inv = 1'b1;
      endcase
      alu_y     = t[7:0];
      alu_flags = {inv, (inv ? 1'b0 : ^t[7:0]), (inv ? 1'b0 : (t[7:0] == 8'd0)), bo, co};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      // ---- reset state ----
      #2;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_r0_ready_in_reset", r0_ready, 0);
      r0_valid = 1'b1;
      #1;
      check("rst_r0_ready_held", r0_ready, 0);
      r0_valid = 1'b0;
      check("rst_err_cnt", err_cnt, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick();

      // ---- single ADD from r0: 55+67=122, parity 1 ----
      r0_valid = 1'b1; r0_op = 4'd1; r0_a = 8'd55; r0_b = 8'd67; r0_cin = 1'b0;
      #1;
      check("add_r0_ready", r0_ready, 1);
      check("add_r1_ready", r1_ready, 0);
      tick();
      r0_valid = 1'b0;
      check("add_exec_busy", busy, 1);
      check("add_exec_rsp_valid", rsp_valid, 0);
      check("add_alu_op", alu_op, 1);
      check("add_alu_a", alu_a, 55);
      tick();
      check("add_rsp_valid", rsp_valid, 1);
      check("add_rsp_id", rsp_id, 0);
      check("add_rsp_y", rsp_y, 122);
      check("add_rsp_flags", rsp_flags, 5'b01000);
      rsp_ready = 1'b1;
      tick();
      check("add_done_valid", rsp_valid, 0);
      check("add_done_busy", busy, 0);
      rsp_ready = 1'b0;

      // ---- round-robin alternation with both requesters valid ----
      do_reset();
      r0_valid = 1'b1; r0_op = 4'd3; r0_a = 8'd100; r0_b = 8'd10;
      r1_valid = 1'b1; r1_op = 4'd3; r1_a = 8'd10;  r1_b = 8'd10;
      rsp_ready = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("rr_r0_ready", r0_ready, (i % 2 == 0) ? 1 : 0);
         check("rr_r1_ready", r1_ready, (i % 2 == 1) ? 1 : 0);
         tick();
         check("rr_exec_r0_ready", r0_ready, 0);
         tick();
         check("rr_rsp_valid", rsp_valid, 1);
         check("rr_rsp_id", rsp_id, i % 2);
         check("rr_rsp_y", rsp_y, (i % 2 == 0) ? 90 : 0);
         check("rr_rsp_flags", rsp_flags, (i % 2 == 0) ? 5'b00000 : 5'b00100);
         tick();
      end
      r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
      #1;

      // ---- response back-pressure ----
      do_reset();
      r0_valid = 1'b1; r0_op = 4'd1; r0_a = 8'd55; r0_b = 8'd67;
      r1_valid = 1'b1; r1_op = 4'd6; r1_a = 8'hF0; r1_b = 8'h3C;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_valid", rsp_valid, 1);
         check("bp_rsp_y", rsp_y, 122);
         check("bp_rsp_flags", rsp_flags, 5'b01000);
         check("bp_rsp_id", rsp_id, 0);
         check("bp_ready_both", {r0_ready, r1_ready}, 2'b00);
         check("bp_busy", busy, 1);
         tick();
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      check("bp_release_valid", rsp_valid, 0);
      check("bp_release_busy", busy, 0);
      rsp_ready = 1'b0;

      // ---- invalid opcode counting and saturation ----
      do_reset();
      r1_op = 4'd10; r1_a = 8'd1; r1_b = 8'd2;
      for (int i = 1; i <= 17; i++) begin
         r1_valid = 1'b1;
         #1;
         check("inv_r1_ready", r1_ready, 1);
         tick();
         r1_valid = 1'b0;
         tick();
         check("inv_flag", rsp_flags[4], 1);
         check("inv_rsp_id", rsp_id, 1);
         check("inv_err_cnt", err_cnt, (i > 15) ? 15 : i);
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
      end
      check("inv_alu_op_kept", alu_op, 10);

      // ---- reset during EXEC drops the transaction ----
      r0_valid = 1'b1; r0_op = 4'd4; r0_a = 8'd10; r0_b = 8'd0;
      tick();
      r0_valid = 1'b0;
      check("mid_exec_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_err_cnt", err_cnt, 0);
      check("mid_rst_alu_a", alu_a, 0);
      check("mid_rst_busy", busy, 0);
      #2;
      rst_n = 1'b1;
      tick();
      check("mid_post_rsp_valid", rsp_valid, 0);
      r0_valid = 1'b1; r1_valid = 1'b1; r1_op = 4'd4; r1_a = 8'd50;
      #1;
      check("mid_prio_r0", r0_ready, 1);
      check("mid_prio_r1", r1_ready, 0);
      tick();
      r0_valid = 1'b0; r1_valid = 1'b0;
      tick();
      check("mid_inc_y", rsp_y, 11);
      check("mid_inc_id", rsp_id, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // ---- lone r1 wins while rr_ptr favours r0 ----
      do_reset();
      r1_valid = 1'b1; r1_op = 4'd8; r1_a = 8'd10; r1_b = 8'd0;
      #1;
      check("solo_r1_ready", r1_ready, 1);
      check("solo_r0_ready", r0_ready, 0);
      tick();
      r1_valid = 1'b0;
      tick();
      check("solo_rsp_valid", rsp_valid, 1);
      check("solo_rsp_y", rsp_y, 20);
      check("solo_rsp_id", rsp_id, 1);
      check("solo_rsp_flags", rsp_flags, 5'b00000);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      // after granting r1, a tie now goes to r0
      r0_valid = 1'b1; r1_valid = 1'b1;
      #1;
      check("solo_next_r0", r0_ready, 1);
      r0_valid = 1'b0; r1_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
